// File: rtl/sync_fsm_param_if.sv
// sync_fsm_param_if: PMA code-group input and SUDI/status output bundle for sync_fsm_param
interface sync_fsm_param_if #(
    parameter int CNT_W = 8
);
    logic [9:0]       PUDI;
    logic             PUDI_indicate;
    logic             code_sync_status;
    logic [10:0]      SUDI;
    logic             SUDI_indicate;
    logic [1:0]       sync_state;
    logic [2:0]       bad_level;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output PUDI, PUDI_indicate,
        input  code_sync_status, SUDI, SUDI_indicate, sync_state, bad_level, loss_count
    );

    modport slave (
        input  PUDI, PUDI_indicate,
        output code_sync_status, SUDI, SUDI_indicate, sync_state, bad_level, loss_count
    );
endinterface

// File: rtl/sync_fsm_param.sv
// sync_fsm_param: parametrised 1000BASE-X PCS receive synchronization FSM tagging code groups with rx_even.
// Define SYNC_STATS_EN to add a saturating sync-loss event counter on loss_count.
module sync_fsm_param #(
    parameter int ACQ_COMMAS   = 3,
    parameter int GOOD_RUN     = 4,
    parameter int LOSS_STRIKES = 3,
    parameter int CNT_W        = 8
) (
    input  logic            Clk,
    input  logic            mr_main_reset,
    sync_fsm_param_if.slave bus
);
    typedef enum logic [1:0] {
        LOSS_OF_SYNC  = 2'd0,
        COMMA_DETECT  = 2'd1,
        ACQUIRE_SYNC  = 2'd2,
        SYNC_ACQUIRED = 2'd3
    } state_t;

    typedef enum logic [1:0] {CG_COMMA, CG_DATA, CG_INVALID} cg_t;

    // Sub-block validity only; running disparity is not tracked here.
    function automatic cg_t ident_pudi(input logic [9:0] cg);
        logic [2:0] n6;
        logic [2:0] n4;
        logic       six_ok;
        n6 = 3'($countones(cg[9:4]));
        n4 = 3'($countones(cg[3:0]));
        six_ok = n6 == 3'd3 ||
                 (n6 == 3'd4 && cg[9:4] != 6'b111100 && cg[9:4] != 6'b001111) ||
                 (n6 == 3'd2 && cg[9:4] != 6'b000011 && cg[9:4] != 6'b110000);
        return (cg[9:3] == 7'b0011111 || cg[9:3] == 7'b1100000) ? CG_COMMA :
               (six_ok && n4 != 3'd0 && n4 != 3'd4) ? CG_DATA : CG_INVALID;
    endfunction

    state_t     state, state_n;
    logic       rx_even, even_n;
    logic [2:0] comma_cnt, comma_n;
    logic [3:0] good_cnt, good_n;
    logic [2:0] bad_lvl, bad_n;
    cg_t        cls;
    logic       is_comma, is_data, cg_good, cg_bad;

    assign cls      = ident_pudi(bus.PUDI);
    assign is_comma = cls == CG_COMMA;
    assign is_data  = cls == CG_DATA;
    assign cg_good  = bus.PUDI_indicate & ~(cls == CG_INVALID | (is_comma & rx_even));
    assign cg_bad   = bus.PUDI_indicate & ~cg_good;

    always_comb begin
        state_n = state;
        comma_n = comma_cnt;
        good_n  = good_cnt;
        bad_n   = bad_lvl;
        if (bus.PUDI_indicate) begin
            case (state)
                LOSS_OF_SYNC: begin
                    if (is_comma) begin
                        state_n = COMMA_DETECT;
                        comma_n = 3'd1;
                    end
                end
                COMMA_DETECT: begin
                    if (is_data && comma_cnt == 3'(ACQ_COMMAS)) begin
                        state_n = SYNC_ACQUIRED;
                        bad_n   = '0;
                        good_n  = '0;
                    end else if (is_data) begin
                        state_n = ACQUIRE_SYNC;
                    end else begin
                        state_n = LOSS_OF_SYNC;
                        comma_n = '0;
                    end
                end
                ACQUIRE_SYNC: begin
                    if (is_comma && !rx_even) begin
                        state_n = COMMA_DETECT;
                        comma_n = comma_cnt + 3'd1;
                    end else if (cg_bad) begin
                        state_n = LOSS_OF_SYNC;
                        comma_n = '0;
                    end
                end
                SYNC_ACQUIRED: begin
                    if (cg_bad && bad_lvl == 3'(LOSS_STRIKES)) begin
                        state_n = LOSS_OF_SYNC;
                        comma_n = '0;
                        bad_n   = '0;
                        good_n  = '0;
                    end else if (cg_bad) begin
                        bad_n  = bad_lvl + 3'd1;
                        good_n = '0;
                    end else if (bad_lvl != '0 && good_cnt + 4'd1 == 4'(GOOD_RUN)) begin
                        bad_n  = bad_lvl - 3'd1;
                        good_n = '0;
                    end else if (bad_lvl != '0) begin
                        good_n = good_cnt + 4'd1;
                    end
                end
                default: state_n = LOSS_OF_SYNC;
            endcase
        end
        even_n = (state_n == COMMA_DETECT) ? 1'b1 : ~rx_even;
    end

    always_ff @(posedge Clk) begin
        if (mr_main_reset) begin
            state                <= LOSS_OF_SYNC;
            rx_even              <= 1'b0;
            comma_cnt            <= '0;
            good_cnt             <= '0;
            bad_lvl              <= '0;
            bus.SUDI             <= '0;
            bus.SUDI_indicate    <= 1'b0;
            bus.code_sync_status <= 1'b0;
        end else begin
            bus.SUDI_indicate <= bus.PUDI_indicate;
            if (bus.PUDI_indicate) begin
                state                <= state_n;
                rx_even              <= even_n;
                comma_cnt            <= comma_n;
                good_cnt             <= good_n;
                bad_lvl              <= bad_n;
                bus.SUDI             <= {bus.PUDI, even_n};
                bus.code_sync_status <= state_n == SYNC_ACQUIRED;
            end
        end
    end

    assign bus.sync_state = state;
    assign bus.bad_level  = bad_lvl;

`ifdef SYNC_STATS_EN
    logic             loss_evt;
    logic [CNT_W-1:0] loss_cnt;

    assign loss_evt = bus.PUDI_indicate && state == SYNC_ACQUIRED && state_n == LOSS_OF_SYNC;

    always_ff @(posedge Clk) begin
        if (mr_main_reset)
            loss_cnt <= '0;
        else if (loss_evt && !(&loss_cnt))
            loss_cnt <= loss_cnt + 1'b1;
    end

    assign bus.loss_count = loss_cnt;
`else
    assign bus.loss_count = '0;
`endif
endmodule

// File: tb/tb_sync_fsm_param.sv
// tb_sync_fsm_param: scoreboard bench driving a default instance and an ACQ_COMMAS=1/LOSS_STRIKES=1 instance in parallel.
module tb_sync_fsm_param;
    localparam int CNT_W = 8;

    // 0 K28.5-, 1 K28.5+, 2 D16.2, 3 D21.5, 4 D0.0, 5..7 invalid
    localparam logic [9:0] SYM [8] = '{10'b0011111010, 10'b1100000101, 10'b0110110101, 10'b1010101010,
                                       10'b1001110100, 10'b0000000000, 10'b1111111111, 10'b1111001111};
    localparam int KIND [8] = '{0, 0, 1, 1, 1, 2, 2, 2};

    typedef struct {
        logic [10:0] sudi;
        int          st;
        int          sync;
        int          bad;
        int          loss;
    } exp_t;

    typedef struct {
        bit synced;
        bit after_comma;
        bit even;
        int commas;
        int strikes;
        int run;
        int losses;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pudi = '0;
    logic       ind = 1'b0;
    int         total = 0;
    int         bad = 0;
    exp_t       q [2][$];
    exp_t       last [2];
    mdl_t       m [2];

    sync_fsm_param_if #(.CNT_W(CNT_W)) b0 ();
    sync_fsm_param_if #(.CNT_W(CNT_W)) b1 ();

    assign b0.PUDI = pudi;
    assign b0.PUDI_indicate = ind;
    assign b1.PUDI = pudi;
    assign b1.PUDI_indicate = ind;

    sync_fsm_param #(.CNT_W(CNT_W)) u0 (.Clk(clk), .mr_main_reset(rst), .bus(b0));
    sync_fsm_param #(.ACQ_COMMAS(1), .GOOD_RUN(4), .LOSS_STRIKES(1), .CNT_W(CNT_W)) u1 (
        .Clk(clk), .mr_main_reset(rst), .bus(b1));

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endfunction

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.synced = 0; z.after_comma = 0; z.even = 0;
        z.commas = 0; z.strikes = 0; z.run = 0; z.losses = 0;
        return z;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.sudi = '0; e.st = 0; e.sync = 0; e.bad = 0; e.loss = 0;
        return e;
    endfunction

    // Reference: acquisition progress as a comma tally plus a "just saw comma" flag, tracking as strikes/run.
    function automatic void step(input int k, input int kind);
        int  acq = (k == 0) ? 3 : 1;
        int  lim = (k == 0) ? 3 : 1;
        bit  comma = kind == 0;
        bit  dat = kind == 1;
        bit  good = dat || (comma && !m[k].even);
        if (m[k].synced) begin
            if (!good && m[k].strikes == lim) begin
                m[k].synced = 0; m[k].commas = 0; m[k].strikes = 0; m[k].run = 0; m[k].losses++;
            end else if (!good) begin
                m[k].strikes++; m[k].run = 0;
            end else if (m[k].strikes > 0) begin
                m[k].run++;
                if (m[k].run == 4) begin m[k].strikes--; m[k].run = 0; end
            end
        end else if (m[k].after_comma) begin
            m[k].after_comma = 0;
            if (dat && m[k].commas == acq) begin m[k].synced = 1; m[k].strikes = 0; m[k].run = 0; end
            else if (!dat) m[k].commas = 0;
        end else if (comma && (m[k].commas == 0 || !m[k].even)) begin
            m[k].commas++; m[k].after_comma = 1;
        end else if (!good) begin
            m[k].commas = 0;
        end
        m[k].even = m[k].after_comma ? 1'b1 : !m[k].even;
    endfunction

    function automatic void push(input int k, input int s);
        exp_t e;
        e.sudi = {SYM[s], m[k].even};
        e.st = m[k].synced ? 3 : m[k].after_comma ? 1 : (m[k].commas > 0) ? 2 : 0;
        e.sync = m[k].synced ? 1 : 0;
        e.bad = m[k].strikes;
`ifdef SYNC_STATS_EN
        e.loss = (m[k].losses > 255) ? 255 : m[k].losses;
`else
        e.loss = 0;
`endif
        q[k].push_back(e);
    endfunction

    task automatic send(input int s);
        @(negedge clk);
        pudi = SYM[s];
        ind = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(k, KIND[s]);
            push(k, s);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ind = 1'b0;
            pudi = 10'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ind = 1'b0;
        for (int k = 0; k < 2; k++) m[k] = mdl_zero();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic acquire(input bit gaps);
        for (int i = 0; i < 3; i++) begin
            send($urandom_range(1));
            if (gaps) idle(1);
            send($urandom_range(4, 2));
            if (gaps) idle(1);
        end
    endtask

    function automatic int pick();
        int r = $urandom_range(9);
        return (r < 5) ? 2 + r % 3 : (r < 8) ? r % 2 : 5 + $urandom_range(2);
    endfunction

    task automatic mon(input int k, input logic r, input logic [10:0] sudi, input logic si,
                       input logic [1:0] st, input logic cs, input logic [2:0] bl,
                       input logic [CNT_W-1:0] lc);
        exp_t e;
        if (r) begin
            q[k].delete();
            e = rst_exp();
            chk("reset_sudi_indicate", k, int'(si), 0);
        end else if (si) begin
            if (q[k].size() == 0) begin
                chk("spurious_sudi_indicate", k, 1, 0);
                e = last[k];
            end else begin
                e = q[k].pop_front();
            end
        end else begin
            if (q[k].size() != 0) begin
                chk("missing_sudi_indicate", k, 0, 1);
                void'(q[k].pop_front());
            end
            e = last[k];
        end
        chk("sudi", k, int'(sudi), int'(e.sudi));
        chk("sync_state", k, int'(st), e.st);
        chk("code_sync_status", k, int'(cs), e.sync);
        chk("bad_level", k, int'(bl), e.bad);
        chk("loss_count", k, int'(lc), e.loss);
        last[k] = e;
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(0, rst, b0.SUDI, b0.SUDI_indicate, b0.sync_state, b0.code_sync_status, b0.bad_level, b0.loss_count);
        mon(1, rst, b1.SUDI, b1.SUDI_indicate, b1.sync_state, b1.code_sync_status, b1.bad_level, b1.loss_count);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k] = mdl_zero();
            last[k] = rst_exp();
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        acquire(0);
        send(5);
        repeat (4) send(2);
        if (!m[0].even) send(3);
        send(0);
        repeat (4) send(2);
        repeat (4) send(5);
        acquire(1);
        send(0); send(2); send(1);
        do_reset();
        acquire(0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) acquire($urandom_range(1));
            for (int j = 0; j < 15; j++) begin
                send(pick());
                if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
            end
            if ($urandom_range(19) == 0) do_reset();
        end
        // Enough sync/loss cycles to drive an 8-bit loss counter into saturation.
        for (int i = 0; i < 270; i++) begin
            acquire(0);
            repeat (4) send(6);
        end
        idle(3);
        chk("queue_drained", 0, q[0].size() + q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fsm_param.md
Name: sync_fsm_param

Overview:
- Parametrised successor to the 1000BASE-X PCS receive synchronization FSM (IEEE 802.3 Cl.36 style).
- Acquires and monitors code-group alignment from the PMA 10-bit stream and tags each code group with rx_even into SUDI.
- Acquisition comma count, good-run length and loss threshold are parameters.
- All transitions are qualified by PUDI_indicate, so the block tolerates gapped input. Sits between the PMA deserializer and the PCS receive FSM.

Parameters:
- ACQ_COMMAS, 3: number of even-aligned commas needed to declare sync. Legal range 1..7.
- GOOD_RUN, 4: consecutive good code groups that remove one bad strike. Legal range 1..15.
- LOSS_STRIKES, 3: strikes tolerated while synced; a bad code group arriving at this level drops sync. Legal range 1..7.
- CNT_W, 8: width of the statistics counters.

Ports:
- Clk  in  1  Clock.
- mr_main_reset  in  1  Synchronous, active-high reset.
- PUDI  in  10  Code group from the PMA.
- PUDI_indicate  in  1  PUDI is a new code group this cycle.
- code_sync_status  out  1  1 = synchronized.
- SUDI  out  11  {code group, rx_even}.
- SUDI_indicate  out  1  SUDI valid this cycle.
- sync_state  out  2  Encoded state: 0 LOSS_OF_SYNC, 1 COMMA_DETECT, 2 ACQUIRE_SYNC, 3 SYNC_ACQUIRED.
- bad_level  out  3  Current strike count.
- loss_count  out  CNT_W  Number of sync-loss events (see Optional Feature).

Behaviour:
- Design style: one clock, Clk. Reset is synchronous and active-high on mr_main_reset; it wins over everything and may be asserted mid-acquisition.
- Reset values: sync_state=0, code_sync_status=0, bad_level=0, SUDI=0, SUDI_indicate=0, loss_count=0. Internal: rx_even=0, comma_cnt=0, good_cnt=0.
- Code-group classification: PUDI is classified by an IdentPUDI instance into COMMA, D and INVALID.
  - cggood = PUDI_indicate & ~(INVALID | (COMMA & rx_even)).
  - cgbad = PUDI_indicate & ~cggood.
  - rx_even here is the registered parity of the previous code group.
- When PUDI_indicate=0: all state, counters and rx_even hold; SUDI_indicate=0 next cycle; SUDI holds.
- rx_even update on each indicated code group:
  - Set to 1 if the next state is COMMA_DETECT.
  - Otherwise toggles.
- SUDI output: on an indicated code group, SUDI <= {PUDI, new rx_even} and SUDI_indicate <= 1. Latency is 1 cycle.
- LOSS_OF_SYNC: COMMA → COMMA_DETECT with comma_cnt=1. Otherwise stay.
- COMMA_DETECT (next indicated code group):
  - D and comma_cnt==ACQ_COMMAS → SYNC_ACQUIRED, with bad_level=0 and good_cnt=0.
  - D otherwise → ACQUIRE_SYNC.
  - Anything else → LOSS_OF_SYNC.
- ACQUIRE_SYNC:
  - COMMA & rx_even==0 → COMMA_DETECT, comma_cnt+1.
  - Else cgbad → LOSS_OF_SYNC, comma_cnt=0.
  - Else stay.
- SYNC_ACQUIRED, on cgbad:
  - If bad_level==LOSS_STRIKES → LOSS_OF_SYNC, comma_cnt=0; loss event.
  - Otherwise bad_level+1 and good_cnt=0.
- SYNC_ACQUIRED, on cggood with bad_level>0:
  - good_cnt+1.
  - When good_cnt reaches GOOD_RUN: bad_level-1 and good_cnt=0, in the same cycle.
- SYNC_ACQUIRED, on cggood with bad_level==0: good_cnt stays 0.
- code_sync_status = (sync_state==3), registered; it changes on the same edge as sync_state.
- With ACQ_COMMAS=1: the first comma followed by D gives sync.
- Default parameters reproduce Cl.36 exactly: 4th unrecovered bad drops sync; 4 goods clear one strike.

Optional Feature:
- Macro: SYNC_STATS_EN.
- Defined:
  - loss_count increments on each SYNC_ACQUIRED → LOSS_OF_SYNC transition and saturates at all-ones.
  - It is not incremented by reset.
  - It is cleared only by mr_main_reset.
- Undefined: loss_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Acquire: after reset, drive K28.5, D16.2, K28.5, D16.2, K28.5, D16.2, each with indicate=1 → code_sync_status=1 on the cycle after the 6th code group. SUDI LSBs read 1,0,1,0,1,0.
- Gapped input: same sequence with indicate=0 between every code group → same sync result after 6 indicated groups; rx_even and state hold during gaps; SUDI_indicate pulses only on indicated groups.
- Loss: in sync, drive 4 INVALID groups back-to-back → bad_level steps 1,2,3, then sync_state=0 and code_sync_status=0. loss_count=1 with SYNC_STATS_EN.
- Recovery: in sync, 1 INVALID then 4 D groups → bad_level goes 1 then back to 0 after the 4th good; sync is held.
- Odd comma: in sync, drive a comma when rx_even==1 → counted as bad, bad_level=1.
- Reset mid-acquisition: assert mr_main_reset after 2 commas → all outputs return to reset values next edge; 3 fresh comma/D pairs are required for sync.
- Parameter sweep: ACQ_COMMAS=1, LOSS_STRIKES=1 → sync after K28.5,D16.2; loss after 2 consecutive bad groups.
